// File: rtl/wr_cmd_queue.sv
// Write-command queue: a FIFO of CPU write commands, each issued to the write controller
// through a one-cycle strobe, with an acknowledge timeout that sets a sticky error flag.
// Optional macro WR_CMD_QUEUE_STATS_EN adds saturating issue and timeout counters.
module wr_cmd_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [1:0]               i_cim_sel,
  input  logic                     i_bank_sel,
  input  logic [7:0]               i_row,
  input  logic [10:0]              i_inbuffer_adr,
  input  logic                     i_flush,
  input  logic                     i_err_clr,
  output logic                     o_rw_n,
  output logic                     o_rq_n,
  output logic [1:0]               o_cim_sel,
  output logic                     o_bank_sel,
  output logic [7:0]               o_row,
  output logic [10:0]              o_inbuffer_adr,
  input  logic                     i_wr_busy,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_err,
  output logic                     o_idle
`ifdef WR_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]              o_issue_cnt,
  output logic [7:0]               o_timeout_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [21:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [21:0]     cmd_q, cmd_d;
  logic            strobe_q, strobe_d;
  logic            err_q, err_d;
  logic            push, pop, timeout;
  logic [21:0]     cmd_in;

  assign cmd_in      = {i_cim_sel, i_bank_sel, i_row, i_inbuffer_adr};
  assign o_cmd_ready = (level_q != LW'(DEPTH));
  assign o_idle      = (state_q == IDLE) && (level_q == '0);
  assign o_rw_n      = strobe_q;
  assign o_rq_n      = strobe_q;
  assign {o_cim_sel, o_bank_sel, o_row, o_inbuffer_adr} = cmd_q;
  assign o_level     = level_q;
  assign o_err       = err_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cmd_d    = cmd_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    timeout  = 1'b0;
    push     = i_cmd_valid && o_cmd_ready && !i_flush;

    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle wins: nothing queued may become in-flight.
        if (level_q != '0 && !i_flush) begin
          pop      = 1'b1;
          cmd_d    = mem_q[rd_ptr_q];
          strobe_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_wr_busy) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_wr_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (timeout)        err_d = 1'b1;
    else if (i_err_clr) err_d = 1'b0;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      timer_q  <= '0;
      cmd_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      cmd_q    <= cmd_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

`ifdef WR_CMD_QUEUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    issue_cnt_d   = (pop && issue_cnt_q != '1) ? issue_cnt_q + 16'd1 : issue_cnt_q;
    timeout_cnt_d = (timeout && timeout_cnt_q != '1) ? timeout_cnt_q + 8'd1 : timeout_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign o_issue_cnt   = issue_cnt_q;
  assign o_timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_wr_cmd_queue.sv
// Randomized bench for wr_cmd_queue against a queue-based behavioural model of the
// command flow; stats counters are checked when WR_CMD_QUEUE_STATS_EN is defined.
module tb_wr_cmd_queue;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid, o_cmd_ready;
  logic [1:0]  i_cim_sel;
  logic        i_bank_sel;
  logic [7:0]  i_row;
  logic [10:0] i_inbuffer_adr;
  logic        i_flush, i_err_clr;
  logic        o_rw_n, o_rq_n;
  logic [1:0]  o_cim_sel;
  logic        o_bank_sel;
  logic [7:0]  o_row;
  logic [10:0] o_inbuffer_adr;
  logic        i_wr_busy;
  logic [2:0]  o_level;
  logic        o_err, o_idle;
`ifdef WR_CMD_QUEUE_STATS_EN
  logic [15:0] o_issue_cnt;
  logic [7:0]  o_timeout_cnt;
`endif

  wr_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cim_sel(i_cim_sel), .i_bank_sel(i_bank_sel), .i_row(i_row),
    .i_inbuffer_adr(i_inbuffer_adr), .i_flush(i_flush), .i_err_clr(i_err_clr),
    .o_rw_n(o_rw_n), .o_rq_n(o_rq_n), .o_cim_sel(o_cim_sel), .o_bank_sel(o_bank_sel),
    .o_row(o_row), .o_inbuffer_adr(o_inbuffer_adr), .i_wr_busy(i_wr_busy),
    .o_level(o_level), .o_err(o_err), .o_idle(o_idle)
`ifdef WR_CMD_QUEUE_STATS_EN
    , .o_issue_cnt(o_issue_cnt), .o_timeout_cnt(o_timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: pending commands in a queue, plus the command being handled and
  // where it is in its life (just strobed, awaiting busy, awaiting release, or none).
  typedef enum {M_NONE, M_STROBE, M_AWAIT_ACK, M_AWAIT_DONE} phase_t;
  logic [21:0] mq[$];
  logic [21:0] m_cur;
  phase_t      m_ph;
  int          m_waited;
  bit          m_err;
  int          m_icnt, m_tcnt;

  task automatic model_edge(input logic [21:0] cmd);
    bit ready, timed_out;
    if (!rst_n) begin
      mq.delete(); m_cur = '0; m_ph = M_NONE; m_waited = 0; m_err = 0; m_icnt = 0; m_tcnt = 0;
      return;
    end
    ready = (mq.size() != DEPTH);
    timed_out = 0;
    case (m_ph)
      M_NONE:
        if (mq.size() > 0 && !i_flush) begin
          m_cur = mq.pop_front();
          m_ph  = M_STROBE;
          if (m_icnt < 16'hFFFF) m_icnt++;
        end
      M_STROBE: begin m_ph = M_AWAIT_ACK; m_waited = 0; end
      M_AWAIT_ACK:
        if (i_wr_busy) m_ph = M_AWAIT_DONE;
        else begin
          m_waited++;
          if (m_waited == ACK_TIMEOUT) begin
            timed_out = 1; m_ph = M_NONE;
            if (m_tcnt < 8'hFF) m_tcnt++;
          end
        end
      M_AWAIT_DONE: if (!i_wr_busy) m_ph = M_NONE;
      default: ;
    endcase
    if (timed_out) m_err = 1;
    else if (i_err_clr) m_err = 0;
    if (i_flush) mq.delete();
    else if (i_cmd_valid && ready) mq.push_back(cmd);
  endtask

  task automatic compare_all();
    check("cmd_ready", 32'(o_cmd_ready), 32'(mq.size() != DEPTH));
    check("level", 32'(o_level), 32'(mq.size()));
    check("rw_n", 32'(o_rw_n), 32'(m_ph == M_STROBE));
    check("rq_n", 32'(o_rq_n), 32'(m_ph == M_STROBE));
    check("fields", 32'({o_cim_sel, o_bank_sel, o_row, o_inbuffer_adr}), 32'(m_cur));
    check("err", 32'(o_err), 32'(m_err));
    check("idle", 32'(o_idle), 32'(m_ph == M_NONE && mq.size() == 0));
`ifdef WR_CMD_QUEUE_STATS_EN
    check("issue_cnt", 32'(o_issue_cnt), 32'(m_icnt));
    check("timeout_cnt", 32'(o_timeout_cnt), 32'(m_tcnt));
`endif
  endtask

  initial begin
    int busy_pct, valid_pct;
    int busy_tbl[4];
    logic [21:0] cmd;
    busy_tbl = '{0, 30, 60, 90};
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_flush = 1'b0; i_err_clr = 1'b0; i_wr_busy = 1'b0;
    i_cim_sel = '0; i_bank_sel = 1'b0; i_row = '0; i_inbuffer_adr = '0;
    cmd = '0;
    mq.delete(); m_cur = '0; m_ph = M_NONE; m_waited = 0; m_err = 0; m_icnt = 0; m_tcnt = 0;

    for (int seg = 0; seg < 16; seg++) begin
      busy_pct  = busy_tbl[seg % 4];
      valid_pct = (seg < 2) ? 100 : int'($urandom_range(20, 90));
      for (int c = 0; c < 150; c++) begin
        if (seg == 0 && c < 2) rst_n = 1'b0;
        else rst_n = ($urandom_range(0, 199) != 0);
        cmd = 22'($urandom);
        {i_cim_sel, i_bank_sel, i_row, i_inbuffer_adr} = cmd;
        i_cmd_valid = ($urandom_range(0, 99) < valid_pct);
        i_wr_busy   = ($urandom_range(0, 99) < busy_pct);
        i_flush     = ($urandom_range(0, 99) < 3);
        i_err_clr   = ($urandom_range(0, 99) < 5);
        @(posedge clk);
        model_edge(cmd);
        #1;
        compare_all();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
